// File: rtl/bool_pack_scheduler.sv
// Stage 1 front end: packs up to three compatible boolean symbols into one pipeline slot.
// Packing, the idle timeout and flush handling exist only when SCHED_BOOL_PACK_EN is defined.
module bool_pack_scheduler #(
  parameter int RANGE_WIDTH   = 16,
  parameter int SYMBOL_WIDTH  = 4,
  parameter int TIMEOUT_WIDTH = 4,
  parameter int TIMEOUT       = 8
) (
  input  logic                    clk_sched,
  input  logic                    reset_sched_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_bool_flag,
  input  logic                    flush,
  input  logic                    pipe_ready,
  output logic                    out_valid,
  output logic [RANGE_WIDTH-1:0]  out_fl,
  output logic [RANGE_WIDTH-1:0]  out_fh,
  output logic [SYMBOL_WIDTH:0]   out_nsyms,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_1,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_2,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_3,
  output logic                    out_bool_flag_1,
  output logic                    out_bool_flag_2,
  output logic                    out_bool_flag_3,
  output logic [1:0]              out_count,
  output logic                    busy
);

  if (TIMEOUT < 1 || TIMEOUT > (2 ** TIMEOUT_WIDTH) - 1) begin : g_bad_timeout
    $error("bool_pack_scheduler: TIMEOUT does not fit in TIMEOUT_WIDTH");
  end

  logic                    r_out_valid;
  logic [RANGE_WIDTH-1:0]  r_out_fl;
  logic [RANGE_WIDTH-1:0]  r_out_fh;
  logic [SYMBOL_WIDTH:0]   r_out_nsyms;
  logic [SYMBOL_WIDTH-1:0] r_out_sym1;
  logic [SYMBOL_WIDTH-1:0] r_out_sym2;
  logic [SYMBOL_WIDTH-1:0] r_out_sym3;
  logic                    r_out_flag1;
  logic                    r_out_flag2;
  logic                    r_out_flag3;
  logic [1:0]              r_out_count;

  logic                    w_accept;
  logic                    w_load;
  logic [RANGE_WIDTH-1:0]  w_ld_fl;
  logic [RANGE_WIDTH-1:0]  w_ld_fh;
  logic [SYMBOL_WIDTH:0]   w_ld_nsyms;
  logic [SYMBOL_WIDTH-1:0] w_ld_sym1;
  logic [SYMBOL_WIDTH-1:0] w_ld_sym2;
  logic [SYMBOL_WIDTH-1:0] w_ld_sym3;
  logic                    w_ld_flag1;
  logic                    w_ld_flag2;
  logic                    w_ld_flag3;
  logic [1:0]              w_ld_count;
  logic                    w_busy;

  // The output register may be reloaded in the same cycle its slot transfers.
  assign in_ready = !r_out_valid || pipe_ready;
  assign w_accept = in_valid && in_ready;

`ifdef SCHED_BOOL_PACK_EN
  typedef enum logic [1:0] {EMPTY, PACK1, PACK2, SOLO} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [RANGE_WIDTH-1:0]   r_buf_fl;
  logic [RANGE_WIDTH-1:0]   r_buf_fh;
  logic [SYMBOL_WIDTH:0]    r_buf_nsyms;
  logic [SYMBOL_WIDTH-1:0]  r_buf_sym1;
  logic [SYMBOL_WIDTH-1:0]  r_buf_sym2;
  logic                     r_flush_pend;
  logic                     w_flush_pend_next;
  logic [TIMEOUT_WIDTH-1:0] r_idle;
  logic [TIMEOUT_WIDTH-1:0] w_idle_next;
  logic [TIMEOUT_WIDTH-1:0] w_idle_inc;
  logic                     w_in_bool;
  logic                     w_compat;
  logic                     w_fp;
  logic                     w_buf_ld1;
  logic                     w_buf_ld2;

  assign w_in_bool  = !in_bool_flag;
  assign w_compat   = w_in_bool && (in_fl == r_buf_fl) && (in_fh == r_buf_fh);
  assign w_fp       = r_flush_pend || flush;
  assign w_idle_inc = (r_idle == TIMEOUT_WIDTH'(TIMEOUT)) ? r_idle
                                                          : r_idle + TIMEOUT_WIDTH'(1);
  assign w_busy     = (r_state != EMPTY) || r_out_valid;

  // Load data defaults to the buffered group; only the direct path overrides it.
  always_comb begin
    w_state_next      = r_state;
    w_idle_next       = r_idle;
    w_flush_pend_next = w_fp;
    w_buf_ld1         = 1'b0;
    w_buf_ld2         = 1'b0;
    w_load            = 1'b0;
    w_ld_fl           = r_buf_fl;
    w_ld_fh           = r_buf_fh;
    w_ld_nsyms        = r_buf_nsyms;
    w_ld_sym1         = r_buf_sym1;
    w_ld_flag1        = (r_state == SOLO);
    w_ld_sym2         = (r_state == PACK2) ? r_buf_sym2 : '0;
    w_ld_flag2        = (r_state != PACK2);
    w_ld_sym3         = '0;
    w_ld_flag3        = 1'b1;
    w_ld_count        = (r_state == PACK2) ? 2'd2 : 2'd1;

    if (w_accept) begin
      w_idle_next = '0;
      case (r_state)
        EMPTY: begin
          if (w_in_bool) begin
            w_buf_ld1    = 1'b1;
            w_state_next = PACK1;
          end else begin
            w_load     = 1'b1;
            w_ld_fl    = in_fl;
            w_ld_fh    = in_fh;
            w_ld_nsyms = in_nsyms;
            w_ld_sym1  = in_symbol;
            w_ld_flag1 = 1'b1;
            w_ld_sym2  = '0;
            w_ld_flag2 = 1'b1;
            w_ld_count = 2'd1;
          end
        end
        PACK1, PACK2: begin
          if (w_compat && r_state == PACK1) begin
            w_buf_ld2    = 1'b1;
            w_state_next = PACK2;
          end else if (w_compat) begin
            w_load       = 1'b1;
            w_ld_sym3    = in_symbol;
            w_ld_flag3   = 1'b0;
            w_ld_count   = 2'd3;
            w_state_next = EMPTY;
          end else begin
            w_load       = 1'b1;
            w_buf_ld1    = 1'b1;
            w_state_next = w_in_bool ? PACK1 : SOLO;
          end
        end
        default: begin
          w_load       = 1'b1;
          w_buf_ld1    = 1'b1;
          w_state_next = w_in_bool ? PACK1 : SOLO;
        end
      endcase
    end else if (r_state == SOLO) begin
      if (in_ready) begin
        w_load       = 1'b1;
        w_state_next = EMPTY;
      end
    end else if (r_state != EMPTY) begin
      w_idle_next = w_idle_inc;
      if (in_ready && (w_idle_inc == TIMEOUT_WIDTH'(TIMEOUT) || w_fp)) begin
        w_load       = 1'b1;
        w_state_next = EMPTY;
        w_idle_next  = '0;
      end
    end

    if (w_state_next == EMPTY) begin
      w_flush_pend_next = 1'b0;
    end
  end

  // Pack buffer, idle counter and pending-flush flag.
  always_ff @(posedge clk_sched or negedge reset_sched_n) begin
    if (!reset_sched_n) begin
      r_state      <= EMPTY;
      r_buf_fl     <= '0;
      r_buf_fh     <= '0;
      r_buf_nsyms  <= '0;
      r_buf_sym1   <= '0;
      r_buf_sym2   <= '0;
      r_idle       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idle       <= w_idle_next;
      r_flush_pend <= w_flush_pend_next;
      if (w_buf_ld1) begin
        r_buf_fl    <= in_fl;
        r_buf_fh    <= in_fh;
        r_buf_nsyms <= in_nsyms;
        r_buf_sym1  <= in_symbol;
      end
      if (w_buf_ld2) begin
        r_buf_sym2 <= in_symbol;
      end
    end
  end
`else
  assign w_busy = r_out_valid || flush;

  always_comb begin
    w_load     = w_accept;
    w_ld_fl    = in_fl;
    w_ld_fh    = in_fh;
    w_ld_nsyms = in_nsyms;
    w_ld_sym1  = in_symbol;
    w_ld_flag1 = in_bool_flag;
    w_ld_sym2  = '0;
    w_ld_flag2 = 1'b1;
    w_ld_sym3  = '0;
    w_ld_flag3 = 1'b1;
    w_ld_count = 2'd1;
  end
`endif

  // Single-entry output register; data holds after transfer, only valid drops.
  always_ff @(posedge clk_sched or negedge reset_sched_n) begin
    if (!reset_sched_n) begin
      r_out_valid <= 1'b0;
      r_out_fl    <= '0;
      r_out_fh    <= '0;
      r_out_nsyms <= '0;
      r_out_sym1  <= '0;
      r_out_sym2  <= '0;
      r_out_sym3  <= '0;
      r_out_flag1 <= 1'b1;
      r_out_flag2 <= 1'b1;
      r_out_flag3 <= 1'b1;
      r_out_count <= 2'd0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_fl    <= w_ld_fl;
      r_out_fh    <= w_ld_fh;
      r_out_nsyms <= w_ld_nsyms;
      r_out_sym1  <= w_ld_sym1;
      r_out_sym2  <= w_ld_sym2;
      r_out_sym3  <= w_ld_sym3;
      r_out_flag1 <= w_ld_flag1;
      r_out_flag2 <= w_ld_flag2;
      r_out_flag3 <= w_ld_flag3;
      r_out_count <= w_ld_count;
    end else if (pipe_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_fl          = r_out_fl;
  assign out_fh          = r_out_fh;
  assign out_nsyms       = r_out_nsyms;
  assign out_symbol_1    = r_out_sym1;
  assign out_symbol_2    = r_out_sym2;
  assign out_symbol_3    = r_out_sym3;
  assign out_bool_flag_1 = r_out_flag1;
  assign out_bool_flag_2 = r_out_flag2;
  assign out_bool_flag_3 = r_out_flag3;
  assign out_count       = r_out_count;
  assign busy            = w_busy;

endmodule

// File: tb/tb_bool_pack_scheduler.sv
// Self-checking bench for bool_pack_scheduler: directed steps plus random traffic against a queue model.
// The model follows SCHED_BOOL_PACK_EN the same way the design does.
module tb_bool_pack_scheduler;

   localparam int TIMEOUT = 8;

   logic        clk_sched = 1'b0;
   logic        reset_sched_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_fl = '0;
   logic [15:0] in_fh = '0;
   logic [3:0]  in_symbol = '0;
   logic [4:0]  in_nsyms = '0;
   logic        in_bool_flag = 1'b1;
   logic        flush = 1'b0;
   logic        pipe_ready = 1'b1;
   logic        out_valid;
   logic [15:0] out_fl;
   logic [15:0] out_fh;
   logic [4:0]  out_nsyms;
   logic [3:0]  out_symbol_1;
   logic [3:0]  out_symbol_2;
   logic [3:0]  out_symbol_3;
   logic        out_bool_flag_1;
   logic        out_bool_flag_2;
   logic        out_bool_flag_3;
   logic [1:0]  out_count;
   logic        busy;

   bool_pack_scheduler #(
      .RANGE_WIDTH(16), .SYMBOL_WIDTH(4), .TIMEOUT_WIDTH(4), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_sched(clk_sched), .reset_sched_n(reset_sched_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms),
      .in_bool_flag(in_bool_flag), .flush(flush), .pipe_ready(pipe_ready),
      .out_valid(out_valid), .out_fl(out_fl), .out_fh(out_fh), .out_nsyms(out_nsyms),
      .out_symbol_1(out_symbol_1), .out_symbol_2(out_symbol_2), .out_symbol_3(out_symbol_3),
      .out_bool_flag_1(out_bool_flag_1), .out_bool_flag_2(out_bool_flag_2),
      .out_bool_flag_3(out_bool_flag_3), .out_count(out_count), .busy(busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk_sched = ~clk_sched;

   typedef struct packed {
      logic [15:0] fl;
      logic [15:0] fh;
      logic [4:0]  nsyms;
      logic [3:0]  sym;
      logic        flag;
   } sym_t;

   typedef struct packed {
      logic [15:0] fl;
      logic [15:0] fh;
      logic [4:0]  nsyms;
      logic [3:0]  sym1;
      logic [3:0]  sym2;
      logic [3:0]  sym3;
      logic        flag1;
      logic        flag2;
      logic        flag3;
      logic [1:0]  count;
   } slot_t;

   sym_t  mBuf[$];
   slot_t mSlot;
   bit    mValid = 0;
   int    mIdle = 0;
   bit    mFlush = 0;

   int nVec = 0;
   int nFail = 0;

   // One comparison: counts the vector and reports any miscompare.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Turns whatever the model buffer holds into one slot, unused lanes 0 / flag 1.
   function automatic slot_t takeBuffer();
      slot_t s;
      int n;
      n = mBuf.size();
      s.fl    = mBuf[0].fl;
      s.fh    = mBuf[0].fh;
      s.nsyms = mBuf[0].nsyms;
      s.count = 2'(n);
      s.sym1  = mBuf[0].sym;
      s.flag1 = mBuf[0].flag;
      s.sym2  = (n > 1) ? mBuf[1].sym : 4'd0;
      s.flag2 = (n > 1) ? mBuf[1].flag : 1'b1;
      s.sym3  = (n > 2) ? mBuf[2].sym : 4'd0;
      s.flag3 = (n > 2) ? mBuf[2].flag : 1'b1;
      mBuf.delete();
      return s;
   endfunction

   // Advances the reference model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit    outFree;
      bit    acc;
      bit    fp;
      bit    emitted;
      slot_t ns;
      sym_t  cur;
      outFree = !mValid || pipe_ready;
      acc     = in_valid && outFree;
      fp      = mFlush || flush;
      emitted = 0;
      ns      = '0;
      cur     = '{fl: in_fl, fh: in_fh, nsyms: in_nsyms, sym: in_symbol, flag: in_bool_flag};
`ifdef SCHED_BOOL_PACK_EN
      if (acc) begin
         mIdle = 0;
         if (mBuf.size() == 0) begin
            mBuf.push_back(cur);
            if (in_bool_flag) begin
               ns = takeBuffer();
               emitted = 1;
            end
         end else if (mBuf[0].flag) begin
            ns = takeBuffer();
            emitted = 1;
            mBuf.push_back(cur);
         end else if (!in_bool_flag && in_fl == mBuf[0].fl && in_fh == mBuf[0].fh) begin
            mBuf.push_back(cur);
            if (mBuf.size() == 3) begin
               ns = takeBuffer();
               emitted = 1;
            end
         end else begin
            ns = takeBuffer();
            emitted = 1;
            mBuf.push_back(cur);
         end
      end else if (mBuf.size() != 0) begin
         if (mBuf[0].flag) begin
            if (outFree) begin
               ns = takeBuffer();
               emitted = 1;
            end
         end else begin
            mIdle = (mIdle + 1 > TIMEOUT) ? TIMEOUT : mIdle + 1;
            if (outFree && (mIdle == TIMEOUT || fp)) begin
               ns = takeBuffer();
               emitted = 1;
               mIdle = 0;
            end
         end
      end
      mFlush = fp && (mBuf.size() != 0);
`else
      if (acc) begin
         mBuf.push_back(cur);
         ns = takeBuffer();
         emitted = 1;
      end
`endif
      if (emitted) begin
         mSlot  = ns;
         mValid = 1;
      end else if (pipe_ready) begin
         mValid = 0;
      end
   endtask

   // Compares all DUT outputs against the model state before the coming edge.
   task automatic checkOutput();
      chk("in_ready", in_ready, !mValid || pipe_ready);
      chk("out_valid", out_valid, mValid);
`ifdef SCHED_BOOL_PACK_EN
      chk("busy", busy, (mBuf.size() != 0) || mValid);
`else
      chk("busy", busy, mValid || flush);
`endif
      if (mValid) begin
         chk("out_fl", out_fl, mSlot.fl);
         chk("out_fh", out_fh, mSlot.fh);
         chk("out_nsyms", out_nsyms, mSlot.nsyms);
         chk("out_count", out_count, mSlot.count);
         chk("out_symbol_1", out_symbol_1, mSlot.sym1);
         chk("out_symbol_2", out_symbol_2, mSlot.sym2);
         chk("out_symbol_3", out_symbol_3, mSlot.sym3);
         chk("out_bool_flag_1", out_bool_flag_1, mSlot.flag1);
         chk("out_bool_flag_2", out_bool_flag_2, mSlot.flag2);
         chk("out_bool_flag_3", out_bool_flag_3, mSlot.flag3);
      end
   endtask

   // Drives one cycle of inputs, checks at the falling edge, returns 1 unit after the rising edge.
   task automatic applyStimulus(input bit v, input logic [15:0] fl, input logic [15:0] fh,
                                input logic [3:0] sym, input logic [4:0] ns, input bit bf,
                                input bit fls, input bit pr);
      in_valid     = v;
      in_fl        = fl;
      in_fh        = fh;
      in_symbol    = sym;
      in_nsyms     = ns;
      in_bool_flag = bf;
      flush        = fls;
      pipe_ready   = pr;
      @(negedge clk_sched);
      checkOutput();
      modelStep();
      @(posedge clk_sched);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, '0, '0, '0, '0, 1, 0, 1);
   endtask

   // Asynchronous reset pulse between clock edges, with reset-value checks.
   task automatic resetDut();
      in_valid = 0;
      flush = 0;
      reset_sched_n = 0;
      #2;
      mBuf.delete();
      mValid = 0;
      mIdle = 0;
      mFlush = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_fl", out_fl, 0);
      chk("rst_out_fh", out_fh, 0);
      chk("rst_out_nsyms", out_nsyms, 0);
      chk("rst_symbols", {out_symbol_1, out_symbol_2, out_symbol_3}, 0);
      chk("rst_flags", {out_bool_flag_1, out_bool_flag_2, out_bool_flag_3}, 3'b111);
      reset_sched_n = 1;
   endtask

   bit          rv;
   bit          rbf;
   bit          rfls;
   bit          rpr;
   logic [15:0] rfl;
   logic [15:0] rfh;
   logic [3:0]  rsym;
   logic [4:0]  rns;

   // Directed steps first, then random traffic with idle bursts and one mid-run reset.
   initial begin
      @(posedge clk_sched);
      #1;
      resetDut();

      applyStimulus(1, 16'h4000, 16'h8000, 4'd1, 5'd2, 0, 0, 1);
      applyStimulus(1, 16'h4000, 16'h8000, 4'd0, 5'd2, 0, 0, 1);
      resetDut();
      applyStimulus(1, 16'h1234, 16'h5678, 4'd5, 5'd8, 1, 0, 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("after_reset_valid", out_valid, 1);
      chk("after_reset_count", out_count, 1);
      chk("after_reset_lanes", {out_symbol_2, out_bool_flag_2, out_symbol_3, out_bool_flag_3},
          10'b0000_1_0000_1);
`endif
      idleCycles(2);

      applyStimulus(1, 16'h4000, 16'h8000, 4'd1, 5'd2, 0, 0, 1);
      applyStimulus(1, 16'h4000, 16'h8000, 4'd0, 5'd2, 0, 0, 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("pack3_not_yet", out_valid, 0);
`endif
      applyStimulus(1, 16'h4000, 16'h8000, 4'd1, 5'd2, 0, 0, 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("pack3_valid", out_valid, 1);
      chk("pack3_count", out_count, 3);
      chk("pack3_symbols", {out_symbol_1, out_symbol_2, out_symbol_3}, 12'h101);
      chk("pack3_flags", {out_bool_flag_1, out_bool_flag_2, out_bool_flag_3}, 3'b000);
`endif
      idleCycles(2);

      applyStimulus(1, 16'h4000, 16'h8000, 4'd1, 5'd2, 0, 0, 1);
      applyStimulus(1, 16'h4000, 16'h8000, 4'd0, 5'd2, 0, 0, 1);
      applyStimulus(1, 16'h4000, 16'h8000, 4'd5, 5'd8, 1, 0, 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("pack2_count", out_count, 2);
      chk("pack2_symbols", {out_symbol_1, out_symbol_2, out_symbol_3}, 12'h100);
      chk("pack2_flags", {out_bool_flag_1, out_bool_flag_2, out_bool_flag_3}, 3'b001);
`endif
      idleCycles(1);
`ifdef SCHED_BOOL_PACK_EN
      chk("solo_count", out_count, 1);
      chk("solo_symbol", out_symbol_1, 5);
      chk("solo_nsyms", out_nsyms, 8);
      chk("solo_flag", out_bool_flag_1, 1);
`endif
      idleCycles(2);

      applyStimulus(1, 16'h4000, 16'h8000, 4'd1, 5'd2, 0, 0, 1);
      idleCycles(TIMEOUT - 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("timeout_early", out_valid, 0);
`endif
      idleCycles(1);
`ifdef SCHED_BOOL_PACK_EN
      chk("timeout_valid", out_valid, 1);
      chk("timeout_count", out_count, 1);
`endif
      idleCycles(2);

      applyStimulus(1, 16'h1000, 16'h3000, 4'd7, 5'd9, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 16'h1000, 16'h3000, 4'd9, 5'd10, 1, 0, 0);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_symbol", out_symbol_1, 7);
         chk("stall_nsyms", out_nsyms, 9);
      end
      applyStimulus(1, 16'h1000, 16'h3000, 4'd9, 5'd10, 1, 0, 1);
      chk("release_in_ready", in_ready, 1);
      chk("release_symbol", out_symbol_1, 9);
      idleCycles(2);

      applyStimulus(1, 16'h4000, 16'h8000, 4'd1, 5'd2, 0, 0, 1);
      applyStimulus(1, 16'h2000, 16'h8000, 4'd0, 5'd2, 0, 0, 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("incompat_count", out_count, 1);
      chk("incompat_fl", out_fl, 16'h4000);
`endif
      applyStimulus(0, '0, '0, '0, '0, 1, 1, 1);
`ifdef SCHED_BOOL_PACK_EN
      chk("flush_valid", out_valid, 1);
      chk("flush_fl", out_fl, 16'h2000);
      chk("flush_count", out_count, 1);
`endif
      idleCycles(2);

      for (int i = 0; i < 3000; i++) begin
         rv   = ($urandom_range(0, 99) < 55) && ((i % 300) < 284);
         rbf  = ($urandom_range(0, 99) < 25);
         rfl  = $urandom_range(0, 1) ? 16'h4000 : 16'h2000;
         rfh  = ($urandom_range(0, 99) < 85) ? 16'h8000 : 16'h9000;
         rsym = rbf ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         rns  = rbf ? 5'($urandom_range(3, 16)) : 5'd2;
         rfls = ($urandom_range(0, 99) < 4);
         rpr  = ($urandom_range(0, 99) < 75);
         applyStimulus(rv, rfl, rfh, rsym, rns, rbf, rfls, rpr);
         if (i == 1500) resetDut();
      end
      idleCycles(TIMEOUT + 4);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/bool_pack_scheduler.md
Name: bool_pack_scheduler

Overview:
- Front-end controller that sequences the symbol stream into the Stage 1 boolean-parallel lanes.
- Accepts one symbol per cycle over a valid/ready handshake.
- Packs up to 3 consecutive compatible boolean symbols into one pipeline slot (lanes 1..3). Non-boolean symbols get a slot of their own.
- Drives the lane symbols, boolean flags, FL/FH and NSYMS registers that feed Stage 1, and honours a pipeline-ready stall.

Parameters:
- RANGE_WIDTH, 16, width of FL/FH.
- SYMBOL_WIDTH, 4, symbol width; NSYMS is SYMBOL_WIDTH+1 bits.
- TIMEOUT_WIDTH, 4, width of the idle counter.
- TIMEOUT, 8, idle cycles before a partial boolean group is force-emitted (1..2^TIMEOUT_WIDTH-1).

Ports:
- clk_sched  in  1  clock.
- reset_sched_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  input symbol accepted when in_valid && in_ready.
- in_fl  in  RANGE_WIDTH  symbol FL.
- in_fh  in  RANGE_WIDTH  symbol FH.
- in_symbol  in  SYMBOL_WIDTH  symbol value.
- in_nsyms  in  SYMBOL_WIDTH+1  alphabet size.
- in_bool_flag  in  1  0 = boolean symbol, 1 = non-boolean (Stage 1 polarity).
- flush  in  1  end-of-stream pulse; emits any partial group.
- pipe_ready  in  1  Stage 1 can take a slot this cycle.
- out_valid  out  1  slot valid.
- out_fl, out_fh  out  RANGE_WIDTH  slot FL/FH (lane 1's).
- out_nsyms  out  SYMBOL_WIDTH+1  slot NSYMS.
- out_symbol_1/2/3  out  SYMBOL_WIDTH each  lane symbols.
- out_bool_flag_1/2/3  out  1 each  lane flags, same polarity as in_bool_flag.
- out_count  out  2  occupied lanes, 1..3.
- busy  out  1  pack buffer non-empty or out_valid.

Behaviour:
- Reset (asynchronous, immediate):
  - All out_* = 0 except out_bool_flag_1/2/3 = 1.
  - out_valid = 0, busy = 0, pack buffer empty, idle counter = 0.
  - Any partial group is discarded.
- Output register is single-entry; a slot transfers when out_valid && pipe_ready.
  - While out_valid && !pipe_ready, all out_* stay stable.
- in_ready = !out_valid || pipe_ready; it is combinational and does not depend on in_valid.
- Compatible: the incoming symbol is boolean AND has in_fl/in_fh equal to the buffered lane 1's FL/FH.
- Pack buffer states:
  - EMPTY.
  - PACK1: one boolean symbol buffered.
  - PACK2: two boolean symbols buffered.
  - SOLO: one non-boolean symbol buffered.
- Transitions on an accepted symbol:
  - EMPTY + non-boolean -> loaded directly into the output register, count = 1; state stays EMPTY.
  - EMPTY + boolean -> PACK1.
  - PACK1 + compatible -> PACK2.
  - PACK2 + compatible -> the 3 lanes go to the output register, count = 3; state -> EMPTY.
  - PACKn + incompatible -> the buffered group goes to the output register, count = n.
    - Incoming boolean -> PACK1.
    - Incoming non-boolean -> SOLO.
  - SOLO + any -> the SOLO symbol goes to the output register.
    - Incoming boolean -> PACK1.
    - Incoming non-boolean -> SOLO.
- Emission without input:
  - SOLO moves to the output register as soon as the output register is free; state -> EMPTY.
- Timeout (PACKn only):
  - The idle counter increments each cycle with no accepted input and resets on acceptance.
  - When the counter reaches TIMEOUT and the output register is free, the group is emitted and the state goes to EMPTY.
  - The counter saturates and holds while the group is blocked.
- flush (the request is held internally until served):
  - Emits the buffer content as soon as the output register is free.
  - flush arriving together with a symbol: the symbol is processed first, then the remaining buffer is flushed.
- Unused lanes: symbol = 0, bool flag = 1.
- Latency:
  - Non-boolean into EMPTY: out_valid 1 cycle after acceptance.
  - Group completed by its 3rd boolean: out_valid 1 cycle after that acceptance.

Optional Feature:
- Macro: SCHED_BOOL_PACK_EN.
- Defined: packing as described above.
- Undefined:
  - Every symbol goes straight to the output register with out_count = 1.
  - The PACK/SOLO states, the idle counter and the timeout logic are not built.
  - flush only affects busy.

Test Plan:
- Reset mid-group: two booleans accepted, then reset_sched_n low -> outputs at reset values; a later non-boolean emits count = 1 with no stale lanes.
- Booleans 1, 0, 1, all with FL = 0x4000 and FH = 0x8000, back-to-back -> one slot count = 3, symbols 1/0/1, flags 0/0/0, out_valid 1 cycle after the 3rd.
- Boolean 1, boolean 0, then non-boolean 5 (NSYMS 8) -> slot count = 2 (1, 0, lane 3 symbol 0, flag 1), next slot count = 1 with symbol 5 and NSYMS 8.
- Single boolean then idle with TIMEOUT = 8 -> slot count = 1 exactly 8 idle cycles after acceptance.
- pipe_ready = 0 for 5 cycles with a full slot -> in_ready = 0 and outputs stable; on release the slot transfers and in_ready returns to 1.
- Boolean with FL 0x4000 then boolean with FL 0x2000 -> two slots of count = 1; flush then emits the second with no timeout wait.
